// File: rtl/addsub_ctrl.sv
// Sequencer for a 16-bit add/sub unit: runs one pass for 16-bit ops and two chained passes
// for 32-bit ops, with per-state handshake timeouts.
module addsub_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wide,
    input  logic        op_sub,
    input  logic        op_cin,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res,
    output logic        res_cout,
    output logic        err,
    output logic        cs,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        SUB,
    output logic        CIN,
    input  logic [15:0] SUM,
    input  logic        COUT,
    input  logic        rdy
);

    typedef enum logic [2:0] {IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, FIN} state_t;

    state_t      state_q;
    logic [15:0] a_hi_q, b_hi_q;
    logic        wide_q, sub_q;
    logic [2:0]  cnt_q;
    logic        done_q, cs_q, sub_o_q, cin_q, res_cout_q, err_q;
    logic [15:0] a_o_q, b_o_q;
    logic [31:0] res_q;

    logic in_req, in_wait, tmo;

    assign in_req  = (state_q == LO_REQ)  || (state_q == HI_REQ);
    assign in_wait = (state_q == LO_WAIT) || (state_q == HI_WAIT);
    // REQ phase gives the unit 4 cycles to go busy; WAIT phase gives it 8 cycles to finish.
    assign tmo     = (in_req && rdy && (cnt_q == 3'd3)) || (in_wait && !rdy && (cnt_q == 3'd7));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            wide_q     <= 1'b0;
            sub_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            sub_o_q    <= 1'b0;
            cin_q      <= 1'b0;
            a_o_q      <= '0;
            b_o_q      <= '0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tmo) begin
                state_q    <= FIN;
                done_q     <= 1'b1;
                err_q      <= 1'b1;
                res_q      <= '0;
                res_cout_q <= 1'b0;
                cs_q       <= 1'b0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req && rdy) begin
                            state_q    <= LO_REQ;
                            a_hi_q     <= op_a[31:16];
                            b_hi_q     <= op_b[31:16];
                            wide_q     <= wide;
                            sub_q      <= op_sub;
                            cs_q       <= 1'b1;
                            a_o_q      <= op_a[15:0];
                            b_o_q      <= op_b[15:0];
                            sub_o_q    <= op_sub;
                            cin_q      <= op_cin & ~op_sub;
                            res_q      <= '0;
                            res_cout_q <= 1'b0;
                            err_q      <= 1'b0;
                            cnt_q      <= '0;
                        end
                    end
                    LO_REQ, HI_REQ: begin
                        if (!rdy) begin
                            state_q <= (state_q == LO_REQ) ? LO_WAIT : HI_WAIT;
                            cs_q    <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    LO_WAIT: begin
                        if (rdy) begin
                            res_q[15:0] <= SUM;
                            res_cout_q  <= COUT;
                            cnt_q       <= '0;
                            if (wide_q) begin
                                // High pass is always an add; subtract is a + ~b with the low carry.
                                state_q <= HI_REQ;
                                cs_q    <= 1'b1;
                                a_o_q   <= a_hi_q;
                                b_o_q   <= sub_q ? ~b_hi_q : b_hi_q;
                                sub_o_q <= 1'b0;
                                cin_q   <= COUT;
                            end else begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    HI_WAIT: begin
                        if (rdy) begin
                            res_q[31:16] <= SUM;
                            res_cout_q   <= COUT;
                            state_q      <= FIN;
                            done_q       <= 1'b1;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    FIN: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign res      = res_q;
    assign res_cout = res_cout_q;
    assign err      = err_q;
    assign cs       = cs_q;
    assign A        = a_o_q;
    assign B        = b_o_q;
    assign SUB      = sub_o_q;
    assign CIN      = cin_q;

endmodule

// File: doc/addsub_ctrl.md
ADDSUB_CTRL -- requirements
Module: addsub_ctrl

Interface
REQ-001 clk  input  1  single clock; all state changes on posedge clk.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req  input  1  issue-side start; sampled only in IDLE.
REQ-004 wide  input  1  0 = 16-bit op, 1 = 32-bit op via two unit passes.
REQ-005 op_sub  input  1  0 = add, 1 = subtract.
REQ-006 op_cin  input  1  carry-in for add; ignored for subtract.
REQ-007 op_a, op_b  input  32 each  operands; bits [31:16] ignored when wide=0.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when res/res_cout/err are valid.
REQ-010 res  output  32  result; [31:16]=0 for 16-bit ops.
REQ-011 res_cout  output  1  final carry-out from the unit (1 = no borrow on subtract).
REQ-012 err  output  1  handshake timeout flag, valid with done.
REQ-013 cs  output  1  chip-select to add/sub unit.
REQ-014 A, B  output  16 each  operand buses to unit.
REQ-015 SUB, CIN  output  1 each  mode and carry-in to unit.
REQ-016 SUM  input  16  unit result; valid only while rdy=1 after a low phase.
REQ-017 COUT  input  1  unit carry-out, same validity as SUM.
REQ-018 rdy  input  1  unit ready: 1 idle/finished, 0 busy.

Function
REQ-019 Operands, wide, op_sub and op_cin SHALL be latched on the cycle req=1 is accepted in IDLE; later input changes have no effect.
REQ-020 States SHALL be IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, FIN.
REQ-021 IDLE->LO_REQ on req=1 and rdy=1; req with rdy=0 SHALL be held off (stay IDLE, not latched).
REQ-022 LO_REQ: cs=1, A=a[15:0], B=b[15:0], SUB=op_sub, CIN=op_cin (0 when op_sub); go to LO_WAIT on first cycle rdy=0.
REQ-023 LO_WAIT: cs=0, A/B/SUB/CIN held; on first cycle rdy=1 capture SUM into res[15:0] and COUT into a carry register; go to HI_REQ if wide, else FIN.
REQ-024 HI_REQ: cs=1, A=a[31:16]; add: B=b[31:16], SUB=0, CIN=low carry; subtract: B=~b[31:16], SUB=0, CIN=low carry; go to HI_WAIT on first cycle rdy=0.
REQ-025 HI_WAIT: cs=0; on first cycle rdy=1 capture SUM into res[31:16], COUT into res_cout; go to FIN.
REQ-026 For 16-bit ops res_cout SHALL equal the LO_WAIT captured COUT and res[31:16] SHALL be 0.
REQ-027 FIN: done=1 for exactly one cycle, then IDLE; res/res_cout/err SHALL hold until the next accepted req.
REQ-028 cs SHALL never be high for more than one pass simultaneously; cs=0 in IDLE, LO_WAIT, HI_WAIT, FIN.
REQ-029 Timeout: a REQ state lasting 4 cycles without rdy=0, or a WAIT state lasting 8 cycles without rdy=1, SHALL go to FIN with err=1; res and res_cout SHALL then read 0.
REQ-030 A wait counter SHALL clear on every state transition.
REQ-031 Latency with a compliant unit: 16-bit op done 5 cycles after accept; 32-bit op done 9 cycles after accept.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and busy=0, done=0, err=0, res=0, res_cout=0, cs=0, A=0, B=0, SUB=0, CIN=0, wait counter=0.
REQ-033 Reset mid-operation SHALL abort without a done pulse; first req after release is accepted normally once rdy=1.

Verification
REQ-034 16-bit add a=0x1234, b=0x0001, cin=1 -> done, res=0x00001236, res_cout=0, err=0, one cs pulse.
REQ-035 16-bit sub a=0x0005, b=0x0007 -> res=0x0000FFFE, res_cout=0.
REQ-036 32-bit add a=0x0000FFFF, b=0x00000001, cin=0 -> two cs pulses, HI pass CIN=1, res=0x00010000, res_cout=0.
REQ-037 32-bit sub a=0x00010000, b=0x00000001 -> HI pass B=0xFFFF, CIN=0, res=0x0000FFFF, res_cout=1.
REQ-038 Unit model holds rdy=1 after cs -> after 4 cycles in LO_REQ: done=1, err=1, res=0, then IDLE.
REQ-039 rst_n low during LO_WAIT of a 32-bit op -> all outputs 0 at once, no done; new 16-bit req after release completes correctly.
